strip_seq: RTL

- Frame sequencer that sits directly upstream of the tricolor LED word sender (doled).
- Holds a pixel buffer of NUM_LEDS 24-bit BGR entries that a host writes.
- On each frame request it drives the doled handshake for exactly 1 START word, then NUM_LEDS LED words in address order, then END_WORDS END words.
- Signals completion to the host.

---
 rtl/strip_seq_pkg.sv | 8 +
 rtl/strip_pixram.sv | 19 +
 rtl/strip_seq.sv | 95 +++++++++
 3 files changed

// File: rtl/strip_seq_pkg.sv
// strip_seq_pkg: word type codes and state/phase encodings shared by the strip sequencer
package strip_seq_pkg;
   localparam logic [1:0] TYPE_START = 2'd0;
   localparam logic [1:0] TYPE_LED = 2'd1;
   localparam logic [1:0] TYPE_END = 2'd2;
   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_FETCH, S_ISSUE, S_ACK, S_DONE} state_t;
   typedef enum logic [1:0] {P_START = TYPE_START, P_LED = TYPE_LED, P_END = TYPE_END} phase_t;
endpackage

// File: rtl/strip_pixram.sv
// strip_pixram: NUM_LEDS x 24 pixel buffer, synchronous read, out-of-range writes dropped
module strip_pixram #(
   parameter int NUM_LEDS = 60,
   parameter int ADDR_W = 10
) (
   input logic strip_clk,
   input logic wr_en,
   input logic [ADDR_W-1:0] wr_addr,
   input logic [23:0] wr_data,
   input logic [ADDR_W-1:0] rd_addr,
   output logic [23:0] rd_data
);
   localparam int IW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
   logic [23:0] mem [NUM_LEDS];
   always_ff @(posedge strip_clk) begin
      if (wr_en && 32'(wr_addr) < NUM_LEDS) mem[wr_addr[IW-1:0]] <= wr_data;
      rd_data <= mem[rd_addr[IW-1:0]];
   end
endmodule

// File: rtl/strip_seq.sv
// strip_seq: drives the doled handshake for one START, NUM_LEDS LED and END_WORDS END words per frame
module strip_seq
   import strip_seq_pkg::*;
#(
   parameter int NUM_LEDS = 60,
   parameter int ADDR_W = 10,
   parameter int END_WORDS = 1
) (
   input logic strip_clk,
   input logic strip_reset,
   input logic wr_en,
   input logic [ADDR_W-1:0] wr_addr,
   input logic [23:0] wr_data,
   input logic frame_start,
   output logic frame_busy = 1'b0,
   output logic frame_done = 1'b0,
   output logic [7:0] blue_out = 8'h0,
   output logic [7:0] green_out = 8'h0,
   output logic [7:0] red_out = 8'h0,
   output logic [1:0] type_out = 2'd0,
   output logic doled_start = 1'b0,
   input logic doled_busy
);
   localparam int CW = $clog2(END_WORDS + 1);
   state_t state = S_IDLE;
   phase_t phase = P_START;
   logic [ADDR_W-1:0] led_idx = '0;
   logic [CW-1:0] end_cnt = '0;
   logic [23:0] rd_data;
   strip_pixram #(.NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W)) u_pixram (
      .strip_clk,
      .wr_en,
      .wr_addr,
      .wr_data,
      .rd_addr(led_idx),
      .rd_data
   );
   // The RAM samples buffer[led_idx] on the edge leaving S_FETCH; S_ISSUE latches it into the outputs.
   always_ff @(posedge strip_clk) begin
      if (strip_reset) begin
         state <= S_IDLE;
         phase <= P_START;
         led_idx <= '0;
         end_cnt <= '0;
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
         doled_start <= 1'b0;
         type_out <= 2'd0;
         {blue_out, green_out, red_out} <= 24'h0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: if (frame_start && !frame_done) begin
               frame_busy <= 1'b1;
               phase <= P_START;
               led_idx <= '0;
               end_cnt <= '0;
               state <= S_SYNC;
            end
            S_SYNC: if (!doled_busy) state <= phase == P_LED ? S_FETCH : S_ISSUE;
            S_FETCH: state <= S_ISSUE;
            S_ISSUE: begin
               doled_start <= 1'b1;
               type_out <= phase;
               {blue_out, green_out, red_out} <= phase == P_LED ? rd_data : 24'h0;
               state <= S_ACK;
            end
            S_ACK: if (doled_busy) begin
               doled_start <= 1'b0;
               state <= S_DONE;
            end
            S_DONE: if (!doled_busy) begin
               if (phase == P_START) begin
                  phase <= P_LED;
                  state <= S_FETCH;
               end else if (phase == P_LED && 32'(led_idx) < NUM_LEDS - 1) begin
                  led_idx <= led_idx + 1'b1;
                  state <= S_FETCH;
               end else if (phase == P_LED) begin
                  phase <= P_END;
                  state <= S_ISSUE;
               end else if (32'(end_cnt) < END_WORDS - 1) begin
                  end_cnt <= end_cnt + 1'b1;
                  state <= S_ISSUE;
               end else begin
                  frame_busy <= 1'b0;
                  frame_done <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
